// File: rtl/gfx_frame_regs.sv
// Double-buffered game/graphics register file: CPU writes shadows, a COMMIT arms a swap
// into the displayed registers at the next frame_end. Optional macro GFX_DEMO_ANIM_EN adds a paddle-1 sweep.
module gfx_frame_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        frame_end,
    output logic [15:0] pad1_x,
    output logic [15:0] pad1_y,
    output logic [15:0] pad2_x,
    output logic [15:0] pad2_y,
    output logic [15:0] ball_x,
    output logic [15:0] ball_y,
    output logic [15:0] ball_z,
    output logic [15:0] score1,
    output logic [15:0] score2,
    output logic [15:0] game_state,
    output logic [15:0] frame_cnt,
    output logic        swap,
    output logic        commit_pending
);
    localparam int          NUM_REGS    = 10;
    localparam logic [3:0]  COMMIT_ADDR = 4'd10;

    typedef enum logic {IDLE, ARMED} state_t;

    state_t      state_reg;
    logic [15:0] frame_cnt_reg;
    logic        swap_reg;
    logic        commit_pending_reg;

    logic commit_wr;
    logic load;
    logic sweep;

    assign commit_wr = wr_en && (wr_addr == COMMIT_ADDR);
    assign load      = (state_reg == ARMED) && frame_end;
    assign sweep     = (state_reg == IDLE) && frame_end;

    function automatic logic [15:0] reset_value(input int idx);
        case (idx)
            0:       reset_value = 16'd100;
            1:       reset_value = 16'd200;
            2:       reset_value = 16'd350;
            3:       reset_value = 16'd250;
            default: reset_value = 16'd0;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [15:0] shadow_reg;
            logic [15:0] active_reg;

            always_ff @(posedge clk) begin
                if (rst)
                    shadow_reg <= reset_value(gi);
                else if (wr_en && (wr_addr == 4'(gi)))
                    shadow_reg <= wr_data;
            end

            // A write landing on the swap edge is not seen here: active takes the old shadow.
            always_ff @(posedge clk) begin
                if (rst)
                    active_reg <= reset_value(gi);
                else if (load)
                    active_reg <= shadow_reg;
`ifdef GFX_DEMO_ANIM_EN
                else if ((gi == 0) && sweep)
                    active_reg <= (active_reg <= 16'd400) ? active_reg + 16'd1 : 16'd100;
`endif
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            frame_cnt_reg      <= 16'd0;
            swap_reg           <= 1'b0;
            commit_pending_reg <= 1'b0;
        end else begin
            swap_reg <= 1'b0;
            if (frame_end)
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            case (state_reg)
                IDLE: begin
                    if (commit_wr) begin
                        state_reg          <= ARMED;
                        commit_pending_reg <= 1'b1;
                    end
                end
                ARMED: begin
                    if (frame_end) begin
                        state_reg          <= IDLE;
                        commit_pending_reg <= 1'b0;
                        swap_reg           <= 1'b1;
                    end
                end
                default: begin
                    state_reg          <= IDLE;
                    commit_pending_reg <= 1'b0;
                end
            endcase
        end
    end

    // sweep is only consumed when the demo animation is built in
    logic unused_sweep;
    assign unused_sweep = sweep;

    assign pad1_x         = g_reg[0].active_reg;
    assign pad1_y         = g_reg[1].active_reg;
    assign pad2_x         = g_reg[2].active_reg;
    assign pad2_y         = g_reg[3].active_reg;
    assign ball_x         = g_reg[4].active_reg;
    assign ball_y         = g_reg[5].active_reg;
    assign ball_z         = g_reg[6].active_reg;
    assign score1         = g_reg[7].active_reg;
    assign score2         = g_reg[8].active_reg;
    assign game_state     = g_reg[9].active_reg;
    assign frame_cnt      = frame_cnt_reg;
    assign swap           = swap_reg;
    assign commit_pending = commit_pending_reg;

endmodule
